// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard/flow controller: decode classes, PC sources,
// FSM states and flush causes.
package pipe_ctrl_pkg;

  typedef enum logic [3:0] {
    IT_ALU   = 4'd0,
    IT_CALL  = 4'd6,
    IT_RET   = 4'd7,
    IT_RETID = 4'd8,
    IT_RETIE = 4'd9
  } instr_type_e;

  typedef enum logic [2:0] {
    PC_SRC0 = 3'd0,
    PC_SRC1 = 3'd1,
    PC_SRC2 = 3'd2,
    PC_MISS = 3'd3,
    PC_PRED = 3'd4,
    PC_INT  = 3'd5
  } pc_sel_e;

  typedef enum logic [1:0] {
    HZ_CHECK = 2'd0,
    HZ_STALL = 2'd1,
    HZ_FLUSH = 2'd2,
    HZ_RESET = 2'd3
  } hz_state_e;

  typedef enum logic [1:0] {
    FC_BRN  = 2'd0,
    FC_CALL = 2'd1,
    FC_RET  = 2'd2,
    FC_INT  = 2'd3
  } flush_cause_e;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hz_match.sv
// RAW match of one decode source operand against all downstream writer stages.
// With PIPE_HZ_FWD_EN only the nearest stage stalls; farther matches become a forward index.
module hz_match #(
  parameter int REG_AW    = 5,
  parameter int N_WSTAGES = 2,
  parameter int FW_W      = $clog2(N_WSTAGES + 1)
) (
  input  logic [REG_AW-1:0]           src_reg,
  input  logic                        src_read,
  input  logic [N_WSTAGES*REG_AW-1:0] wr_reg,
  input  logic [N_WSTAGES-1:0]        wr_en,
  output logic                        stall,
  output logic [FW_W-1:0]             fwd_idx
);

  logic [N_WSTAGES-1:0] match_s;

  // Per-stage match of this operand
  always_comb begin
    match_s = {N_WSTAGES{1'b0}};
    for (int k = 0; k < N_WSTAGES; k++) begin
      match_s[k] = wr_en[k] && src_read && (src_reg == wr_reg[k*REG_AW +: REG_AW]);
    end
  end

`ifdef PIPE_HZ_FWD_EN
  // Load-use on stage 0 stalls; descending scan so the nearest forwarding stage wins
  always_comb begin
    stall   = match_s[0];
    fwd_idx = {FW_W{1'b0}};
    for (int k = N_WSTAGES - 1; k >= 1; k--) begin
      fwd_idx = match_s[k] ? FW_W'(k + 1) : fwd_idx;
    end
  end
`else
  assign stall   = |match_s;
  assign fwd_idx = {FW_W{1'b0}};
`endif

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/flow controller between decode, fetch latch and PC: RAW stall detection and
// per-cause counted flush sequences. Optional forwarding via macro PIPE_HZ_FWD_EN.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW       = 5,
  parameter int N_WSTAGES    = 2,
  parameter int BRANCH_FLUSH = 2,
  parameter int CALL_FLUSH   = 2,
  parameter int RET_FLUSH    = 2,
  parameter int INT_FLUSH    = 3,
  parameter int RESET_FLUSH  = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [REG_AW-1:0]                  reg_a,
  input  logic [REG_AW-1:0]                  reg_b,
  input  logic                               a_read,
  input  logic                               b_read,
  input  logic [N_WSTAGES*REG_AW-1:0]        wr_reg,
  input  logic [N_WSTAGES-1:0]               wr_en,
  input  logic [3:0]                         instr_type,
  input  logic                               branch_miss,
  input  logic                               pred_taken,
  input  logic                               interrupt,
  input  logic                               int_en,
  input  logic [1:0]                         instr_pc_sel,
  output logic                               imem_addr_hold,
  output logic                               fetch_stall,
  output logic                               dec_nop,
  output logic                               dec_int,
  output logic                               pc_inc,
  output logic                               pc_load,
  output logic                               pc_reset,
  output logic [2:0]                         pc_mux_sel,
  output logic [$clog2(N_WSTAGES+1)-1:0]     fwd_sel_a,
  output logic [$clog2(N_WSTAGES+1)-1:0]     fwd_sel_b,
  output logic                               busy
);

  localparam int FW_W      = $clog2(N_WSTAGES + 1);
  localparam int MAX_FLUSH = max_i(max_i(max_i(BRANCH_FLUSH, CALL_FLUSH),
                                         max_i(RET_FLUSH, INT_FLUSH)), RESET_FLUSH);
  localparam int CNT_W     = $clog2(MAX_FLUSH) + 1;

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] BRN_LD   = CNT_W'(BRANCH_FLUSH - 1);
  localparam logic [CNT_W-1:0] CALL_LD  = CNT_W'(CALL_FLUSH - 1);
  localparam logic [CNT_W-1:0] RET_LD   = CNT_W'(RET_FLUSH - 1);
  localparam logic [CNT_W-1:0] INT_LD   = CNT_W'(INT_FLUSH - 1);
  localparam logic [CNT_W-1:0] RST_LD   = CNT_W'(RESET_FLUSH - 1);

  if (BRANCH_FLUSH < 1 || CALL_FLUSH < 1 || RET_FLUSH < 1 || INT_FLUSH < 1 || RESET_FLUSH < 1)
  begin : g_bad_flush
    $error("pipe_hazard_ctrl: every *_FLUSH parameter must be >= 1");
  end

  hz_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  flush_cause_e     cause_s;
  logic             start_s, stall_s;
  logic             stall_a_s, stall_b_s;
  logic [FW_W-1:0]  fwd_a_s, fwd_b_s;
  logic             int_req_s, is_ret_s, stall_req_s;

  hz_match #(.REG_AW(REG_AW), .N_WSTAGES(N_WSTAGES), .FW_W(FW_W)) u_hz_a (
    .src_reg(reg_a), .src_read(a_read), .wr_reg(wr_reg), .wr_en(wr_en),
    .stall(stall_a_s), .fwd_idx(fwd_a_s)
  );

  hz_match #(.REG_AW(REG_AW), .N_WSTAGES(N_WSTAGES), .FW_W(FW_W)) u_hz_b (
    .src_reg(reg_b), .src_read(b_read), .wr_reg(wr_reg), .wr_en(wr_en),
    .stall(stall_b_s), .fwd_idx(fwd_b_s)
  );

  assign int_req_s   = interrupt && int_en;
  assign stall_req_s = stall_a_s || stall_b_s;
  assign is_ret_s    = (instr_type == IT_RET) || (instr_type == IT_RETID) || (instr_type == IT_RETIE);

  function automatic logic [CNT_W-1:0] flush_reload(input flush_cause_e c);
    case (c)
      FC_BRN:  return BRN_LD;
      FC_CALL: return CALL_LD;
      FC_RET:  return RET_LD;
      FC_INT:  return INT_LD;
      default: return BRN_LD;
    endcase
  endfunction

  // Next state, counter and all control outputs; reset overrides everything
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    start_s        = 1'b0;
    cause_s        = FC_BRN;
    stall_s        = 1'b0;
    imem_addr_hold = 1'b0;
    fetch_stall    = 1'b0;
    dec_nop        = 1'b0;
    dec_int        = 1'b0;
    pc_load        = 1'b0;
    pc_reset       = 1'b0;
    pc_mux_sel     = {1'b0, instr_pc_sel};
    fwd_sel_a      = fwd_a_s;
    fwd_sel_b      = fwd_b_s;
    if (reset) begin
      state_d    = HZ_RESET;
      cnt_d      = RST_LD;
      pc_reset   = 1'b1;
      dec_nop    = 1'b1;
      pc_mux_sel = 3'd0;
      fwd_sel_a  = {FW_W{1'b0}};
      fwd_sel_b  = {FW_W{1'b0}};
    end else begin
      case (state_q)
        HZ_RESET: begin
          dec_nop = 1'b1;
          cnt_d   = (cnt_q == CNT_ZERO) ? CNT_ZERO : (cnt_q - CNT_ONE);
          state_d = (cnt_q == CNT_ZERO) ? HZ_CHECK : HZ_RESET;
        end
        HZ_FLUSH: begin
          dec_nop = 1'b1;
          if (branch_miss) begin
            start_s    = 1'b1;
            cause_s    = FC_BRN;
            pc_mux_sel = PC_MISS;
          end else begin
            cnt_d   = cnt_q - CNT_ONE;
            state_d = (cnt_q <= CNT_ONE) ? HZ_CHECK : HZ_FLUSH;
          end
        end
        HZ_CHECK, HZ_STALL: begin
          // STALL re-runs the CHECK evaluation so a cleared hazard releases in the same cycle
          state_d = HZ_CHECK;
          if (branch_miss && (state_q == HZ_STALL)) begin
            start_s    = 1'b1;
            cause_s    = FC_BRN;
            pc_mux_sel = PC_MISS;
          end else if (int_req_s) begin
            start_s    = 1'b1;
            cause_s    = FC_INT;
            dec_int    = 1'b1;
            pc_mux_sel = PC_INT;
          end else if (stall_req_s) begin
            stall_s        = 1'b1;
            imem_addr_hold = 1'b1;
            fetch_stall    = 1'b1;
            dec_nop        = 1'b1;
            state_d        = HZ_STALL;
          end else if (instr_type == IT_CALL) begin
            start_s = 1'b1;
            cause_s = FC_CALL;
          end else if (branch_miss) begin
            start_s    = 1'b1;
            cause_s    = FC_BRN;
            pc_mux_sel = PC_MISS;
          end else if (is_ret_s) begin
            start_s     = 1'b1;
            cause_s     = FC_RET;
            fetch_stall = 1'b1;
          end else if (pred_taken) begin
            pc_load     = 1'b1;
            dec_nop     = 1'b1;
            fetch_stall = 1'b1;
            pc_mux_sel  = PC_PRED;
          end else begin
            state_d = HZ_CHECK;
          end
        end
        default: begin
          state_d = HZ_RESET;
          cnt_d   = RST_LD;
        end
      endcase
      if (start_s) begin
        pc_load = 1'b1;
        dec_nop = 1'b1;
        cnt_d   = flush_reload(cause_s);
        state_d = (cnt_d == CNT_ZERO) ? HZ_CHECK : HZ_FLUSH;
      end else begin
        cnt_d = cnt_d;
      end
    end
  end

  assign pc_inc = !pc_reset && !pc_load && !stall_s;
  assign busy   = !reset && (state_q != HZ_CHECK);

  // State and flush counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= HZ_RESET;
      cnt_q   <= RST_LD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
